// File: rtl/fp_pkg.sv
// Reduced-precision float helpers shared across the ml_inference stages.
// Format is {sign, exp, mant} with no denorms, NaN, inf or rounding.
package fp_pkg;

  localparam int EXP   = 4;
  localparam int MANT  = 4;
  localparam int WIDTH = 1 + EXP + MANT;
  localparam int BIAS  = (1 << (EXP - 1)) - 1;

  typedef struct packed {
    logic            sign;
    logic [EXP-1:0]  exp;
    logic [MANT-1:0] mant;
  } fp_t;

  // Sign-magnitude ordering; +0 and -0 are treated as equal.
  function automatic logic fp_gt(input fp_t a, input fp_t b);
    logic [EXP+MANT-1:0] ma;
    logic [EXP+MANT-1:0] mb;
    ma = {a.exp, a.mant};
    mb = {b.exp, b.mant};
    if (ma == '0 && mb == '0) return 1'b0;
    if (a.sign != b.sign)     return b.sign;
    if (!a.sign)              return ma > mb;
    return ma < mb;
  endfunction

  // Ties keep the stored operand so the result is bit-exact and order-stable.
  function automatic fp_t fp_max(input fp_t stored, input fp_t nw);
    return fp_gt(nw, stored) ? nw : stored;
  endfunction

endpackage

// File: rtl/fp_maxpool_linebuf.sv
// Partial-max line buffer: one entry per output column, combinational read,
// synchronous write at the same index.
module fp_maxpool_linebuf #(
  parameter int DEPTH = 14,
  parameter int WIDTH = 9,
  parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IW-1:0]    idx_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  // Not reset: row 0 of every band overwrites before any read is used.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/fp_maxpool.sv
// Streaming non-overlapping POOL x POOL max-pool over a raster-ordered
// feature map; one pooled value per window, one cycle after its last sample.
module fp_maxpool
  import fp_pkg::*;
#(
  parameter int EXP   = fp_pkg::EXP,
  parameter int MANT  = fp_pkg::MANT,
  parameter int WIDTH = 1 + EXP + MANT,
  parameter int IMG_W = 28,
  parameter int POOL  = 2
) (
  input  logic             clock,
  input  logic             clock_sreset,
  input  logic             data_valid,
  input  logic [WIDTH-1:0] data,
  input  logic             data_sof,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic             result_sof,
  output logic             frame_err
);

  localparam int OCOLS = IMG_W / POOL;
  localparam int KW    = $clog2(POOL);
  localparam int CW    = (OCOLS > 1) ? $clog2(OCOLS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(POOL - 1);
  localparam logic [CW-1:0] C_LAST = CW'(OCOLS - 1);

  logic [KW-1:0] kx_q, kx_d, ky_q, ky_d;
  logic [CW-1:0] ocol_q, ocol_d;
  logic          first_q, first_d;
  fp_t           hmax_q, hmax_d;
  fp_t           res_q, res_d;
  logic          res_vld_q, res_vld_d;
  logic          res_sof_q, res_sof_d;
  logic          ferr_q, ferr_d;

  // A start-of-frame sample is handled as if it sat at the frame origin.
  logic [KW-1:0] kx_e, ky_e;
  logic [CW-1:0] ocol_e;
  fp_t           din, h, v, lb_rd, lb_wd;
  logic          lb_we;

  assign kx_e   = data_sof ? '0 : kx_q;
  assign ky_e   = data_sof ? '0 : ky_q;
  assign ocol_e = data_sof ? '0 : ocol_q;
  assign din    = fp_t'(data);
  assign h      = fp_max(hmax_q, din);
  assign v      = fp_max(lb_rd, h);

  fp_maxpool_linebuf #(
    .DEPTH (OCOLS),
    .WIDTH ($bits(fp_t)),
    .IW    (CW)
  ) u_linebuf (
    .clk_i   (clock),
    .we_i    (lb_we),
    .idx_i   (ocol_e),
    .wdata_i (lb_wd),
    .rdata_o (lb_rd)
  );

  always_comb begin
    kx_d      = kx_q;
    ky_d      = ky_q;
    ocol_d    = ocol_q;
    first_d   = first_q;
    hmax_d    = hmax_q;
    res_d     = res_q;
    res_sof_d = res_sof_q;
    res_vld_d = 1'b0;
    ferr_d    = 1'b0;
    lb_we     = 1'b0;
    lb_wd     = h;
    if (data_valid) begin
      ferr_d = data_sof && (kx_q != '0 || ky_q != '0 || ocol_q != '0);
      if (data_sof) first_d = 1'b1;
      ky_d   = ky_e;
      ocol_d = ocol_e;
      hmax_d = (kx_e == '0) ? din : h;
      if (kx_e == K_LAST) begin
        if (ky_e == K_LAST) begin
          res_d     = v;
          res_vld_d = 1'b1;
          res_sof_d = first_q;
          first_d   = 1'b0;
        end else begin
          lb_we = 1'b1;
          lb_wd = (ky_e == '0) ? h : v;
        end
        kx_d = '0;
        if (ocol_e == C_LAST) begin
          ocol_d = '0;
          ky_d   = (ky_e == K_LAST) ? '0 : ky_e + 1'b1;
        end else begin
          ocol_d = ocol_e + 1'b1;
        end
      end else begin
        kx_d = kx_e + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge clock_sreset) begin
    if (clock_sreset) begin
      kx_q      <= '0;
      ky_q      <= '0;
      ocol_q    <= '0;
      first_q   <= 1'b1;
      hmax_q    <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
      res_sof_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      kx_q      <= kx_d;
      ky_q      <= ky_d;
      ocol_q    <= ocol_d;
      first_q   <= first_d;
      hmax_q    <= hmax_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
      res_sof_q <= res_sof_d;
      ferr_q    <= ferr_d;
    end
  end

  assign result_valid = res_vld_q;
  assign result       = res_q;
  assign result_sof   = res_sof_q;
  assign frame_err    = ferr_q;

endmodule

// File: tb/tb_fp_maxpool.sv
// Directed and randomized checks of fp_maxpool against a window-level
// reference that orders samples by their real value.
module tb_fp_maxpool;

  localparam int IMG_W = 4;
  localparam int POOL  = 2;
  localparam int EXP   = 4;
  localparam int MANT  = 4;
  localparam int W     = 1 + EXP + MANT;
  localparam int BAND  = IMG_W * POOL;

  logic         clock = 1'b0;
  logic         clock_sreset = 1'b0;
  logic         data_valid = 1'b0;
  logic         data_sof = 1'b0;
  logic [W-1:0] data = '0;
  logic         result_valid, result_sof, frame_err;
  logic [W-1:0] result;

  fp_maxpool #(
    .EXP (EXP), .MANT (MANT), .WIDTH (W), .IMG_W (IMG_W), .POOL (POOL)
  ) dut (
    .clock        (clock),
    .clock_sreset (clock_sreset),
    .data_valid   (data_valid),
    .data         (data),
    .data_sof     (data_sof),
    .result_valid (result_valid),
    .result       (result),
    .result_sof   (result_sof),
    .frame_err    (frame_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int ferr_seen = 0;

  // reference state: samples of the current band, position, first flag
  logic [W-1:0] band [BAND];
  int           pos;
  logic         m_first;
  logic [W-1:0] m_res;
  logic         m_sof, m_vld, m_ferr;

  logic [W-1:0] s2 [8] = '{9'h070, 9'h080, 9'h000, 9'h078,
                           9'h060, 9'h170, 9'h078, 9'h070};
  logic [W-1:0] s3 [8] = '{9'h170, 9'h180, 9'h000, 9'h000,
                           9'h180, 9'h180, 9'h000, 9'h000};
  logic [W-1:0] s4 [8] = '{9'h000, 9'h100, 9'h070, 9'h060,
                           9'h100, 9'h100, 9'h078, 9'h170};

  function automatic real fval(input logic [W-1:0] x);
    real mag;
    if (x[W-2:0] == '0) return 0.0;
    mag = (1.0 + real'(int'(x[MANT-1:0])) / real'(1 << MANT)) *
          (2.0 ** (real'(int'(x[W-2:MANT])) - real'((1 << (EXP - 1)) - 1)));
    return x[W-1] ? -mag : mag;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pos = 0; m_first = 1'b1; m_res = '0; m_sof = 1'b0; m_vld = 1'b0; m_ferr = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic s, input logic [W-1:0] d);
    int p, row, col;
    logic [W-1:0] best;
    m_vld = 1'b0;
    m_ferr = 1'b0;
    if (!v) return;
    if (s) begin
      m_ferr = (pos != 0);
      pos = 0;
      m_first = 1'b1;
    end
    p = pos;
    band[p] = d;
    row = p / IMG_W;
    col = p % IMG_W;
    if (row == POOL - 1 && col % POOL == POOL - 1) begin
      // largest real value wins; among equals the earliest in raster order
      best = band[col - POOL + 1];
      for (int r = 0; r < POOL; r++)
        for (int c = col - POOL + 1; c <= col; c++)
          if (fval(band[r * IMG_W + c]) > fval(best)) best = band[r * IMG_W + c];
      m_res = best; m_vld = 1'b1; m_sof = m_first; m_first = 1'b0;
    end
    pos = (p + 1) % BAND;
  endtask

  task automatic step(input logic v, input logic s, input logic [W-1:0] d);
    @(negedge clock);
    data_valid = v; data_sof = s; data = d;
    model_step(v, s, d);
    @(posedge clock);
    #1;
    chkb("result_valid", result_valid, m_vld);
    chk("result", result, m_res);
    if (result_valid) chkb("result_sof", result_sof, m_sof);
    chkb("frame_err", frame_err, m_ferr);
    if (frame_err) ferr_seen++;
  endtask

  task automatic hole();
    step(1'b0, 1'b0, W'($urandom));
  endtask

  task automatic async_reset_check(input string tag);
    #1 clock_sreset = 1'b1;
    #1;
    chkb({tag, "_vld"}, result_valid, 1'b0);
    chk({tag, "_res"}, result, '0);
    chkb({tag, "_sof"}, result_sof, 1'b0);
    chkb({tag, "_ferr"}, frame_err, 1'b0);
    model_reset();
    #1 clock_sreset = 1'b0;
  endtask

  task automatic run_frame(input logic [W-1:0] f [8], input bit holes,
                           input logic [W-1:0] w0, input logic [W-1:0] w1);
    for (int i = 0; i < 8; i++) begin
      if (holes) repeat ($urandom_range(0, 3)) hole();
      step(1'b1, i == 0, f[i]);
      if (i == 5) begin
        chkb("w0_valid", result_valid, 1'b1);
        chk("w0_value", result, w0);
        chkb("w0_sof", result_sof, 1'b1);
      end
      if (i == 7) begin
        chkb("w1_valid", result_valid, 1'b1);
        chk("w1_value", result, w1);
        chkb("w1_sof", result_sof, 1'b0);
      end
    end
  endtask

  initial begin
    model_reset();
    #1 clock_sreset = 1'b1;
    #1;
    chkb("por_vld", result_valid, 1'b0);
    chk("por_res", result, '0);
    chkb("por_sof", result_sof, 1'b0);
    chkb("por_ferr", frame_err, 1'b0);
    @(negedge clock);
    clock_sreset = 1'b0;

    // basic frame, then signed ordering and zero tie
    run_frame(s2, 1'b0, 9'h080, 9'h078);
    hole();
    chkb("hold_valid", result_valid, 1'b0);
    chk("hold_value", result, 9'h078);
    run_frame(s3, 1'b0, 9'h170, 9'h000);
    run_frame(s4, 1'b0, 9'h000, 9'h078);

    // same frame with random holes
    run_frame(s2, 1'b1, 9'h080, 9'h078);

    // async reset landing between edges while a result is on the outputs
    for (int i = 0; i < 6; i++) step(1'b1, i == 0, s2[i]);
    async_reset_check("rst_mid");
    run_frame(s2, 1'b0, 9'h080, 9'h078);

    // frame restarted after three samples
    ferr_seen = 0;
    for (int i = 0; i < 3; i++) step(1'b1, i == 0, W'($urandom));
    run_frame(s2, 1'b0, 9'h080, 9'h078);
    checks++;
    assert (ferr_seen === 1) else begin
      errors++;
      $error("FAIL frame_err_count observed=%0d expected=1", ferr_seen);
    end

    // random traffic with holes, stray sofs and occasional resets
    for (int n = 0; n < 600; n++) begin
      logic v, s;
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 39) == 0);
      step(v, s, W'($urandom));
      if ($urandom_range(0, 99) == 0) async_reset_check("rst_rand");
    end

    @(negedge clock);
    data_valid = 1'b0;
    data_sof = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_maxpool.md
Name: fp_maxpool

Overview:
- Streaming 2-D max-pooling stage in the ml_inference datapath.
- Sits directly downstream of the convolution/activation stage and consumes its raster-ordered floating-point feature-map samples, one per valid cycle.
- Emits one pooled value per non-overlapping POOL x POOL window.
- Uses the team's reduced float format: no denorms, NaN, inf or rounding.

Parameters:
EXP, 4, exponent width
MANT, 4, stored mantissa width
WIDTH, 1+EXP+MANT, sample width {sign, exp, mant}
IMG_W, 28, feature-map row length in samples; must be a multiple of POOL
POOL, 2, window side and stride; must be >= 2

Ports:
clock  in  1  single clock
clock_sreset  in  1  reset, asynchronous, active-high
data_valid  in  1  input sample strobe
data  in  WIDTH  input sample, raster order
data_sof  in  1  qualifies data_valid; marks first sample of a frame
result_valid  out  1  pooled output strobe
result  out  WIDTH  pooled maximum
result_sof  out  1  high with the first pooled output of a frame
frame_err  out  1  one-cycle pulse: data_sof seen while not at frame origin

Behaviour:
- Reset (async assert): result_valid=0, result=0, result_sof=0, frame_err=0, all counters=0, first-output flag=1. Line buffer contents are not reset (row 0 always overwrites).
- Counters, advancing only on data_valid:
  - kx: 0..POOL-1, position within window
  - ocol: 0..IMG_W/POOL-1, output column
  - ky: 0..POOL-1, row within window
  - kx wraps and increments ocol; ocol wraps and increments ky; ky wraps to 0.
  - Frame height is unbounded; only data_sof re-anchors.
- Holes (data_valid=0): all state is held; result_valid=0 that cycle.
- Compare, fp_gt(a,b):
  - Correct signed ordering.
  - Positive vs positive: {exp,mant} unsigned greater.
  - Negative vs negative: {exp,mant} unsigned smaller is greater.
  - Positive > negative.
  - +0 and -0 compare equal.
- Merge, fp_max(stored,new): returns new only if fp_gt(new,stored); ties return stored, bit-exact.
- Horizontal: hmax register.
  - kx==0: load data.
  - Otherwise: hmax <= fp_max(hmax,data).
  - h = fp_max(hmax,data), evaluated combinationally at kx==POOL-1.
- Vertical, at kx==POOL-1:
  - ky==0: linebuf[ocol] <= h.
  - 0<ky<POOL-1: linebuf[ocol] <= fp_max(linebuf[ocol],h).
  - ky==POOL-1: result <= fp_max(linebuf[ocol],h); result_valid <= 1; result_sof <= first flag; first flag cleared.
- Latency: result_valid rises exactly 1 clock after the sample completing the window.
- result is held between strobes.
- Line buffer: IMG_W/POOL x WIDTH entries, read and written at index ocol in the same cycle. Register array or MLAB; read is combinational.
- data_sof handling, on data_valid&data_sof:
  - The sample is processed as if kx=ocol=ky=0.
  - First flag set.
  - frame_err pulses 1 cycle later iff the counters were not all 0.
  - The partial window is discarded.
- Reset mid-window: everything returns to reset values immediately. The next frame must start with data_sof or from the reset origin.

Decomposition:
- Package fp_pkg:
  - typedef fp_t as a packed struct {sign, exp[EXP], mant[MANT]}
  - BIAS constant
  - functions fp_gt and fp_max (shared with other ml_inference stages)
- One sub-module: fp_maxpool_linebuf, the parameterised partial-max line buffer with async read and sync write.

Test Plan:
Config: IMG_W=4, POOL=2, EXP=4, MANT=4. Encodings: 1.0=0x070, 2.0=0x080, 1.5=0x078, 0.5=0x060, -1.0=0x170, -2.0=0x180, 0=0x000, -0=0x100.
1. Reset asserted mid-stream -> result_valid=0, result=0x000, result_sof=0, frame_err=0 in the same cycle. Async check: apply reset between clock edges.
2. sof then rows 0x070,0x080,0x000,0x078 / 0x060,0x170,0x078,0x070 -> results:
   - 0x080 with result_sof=1, 1 clk after sample 6
   - 0x078 with result_sof=0, 1 clk after sample 8
3. All-negative window 0x170,0x180 / 0x180,0x180 (plus filler) -> first result 0x170, proving signed ordering.
4. Zero tie: window 0x000,0x100 / 0x100,0x100 -> result 0x000 (stored operand kept).
5. Scenario 2 with random data_valid holes (0-3 cycles) -> identical result sequence and latency relative to the completing sample.
6. Mid-frame sof after 3 samples, then a clean 8-sample frame -> frame_err pulse once; outputs match scenario 2 exactly.
